// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Optional even-parity support is selected with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// byte_fifo: synchronous FIFO with registered head, full/empty flags and occupancy count.
// Used by uart_tx_buffered (UART_TX_PARITY_EN does not affect this file).
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [AW:0]      count_n;
    logic [WIDTH-1:0] head_n;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO rejects a push even when a pop happens in the same cycle.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign rd_ptr_n = pop_ok ? rd_ptr + AW'(1) : rd_ptr;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        count_n = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
        head_n = mem[rd_ptr_n];
        if (push_ok && (wr_ptr == rd_ptr_n)) begin
            head_n = din;
        end
    end

    // NOTE: storage is deliberately not reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            full   <= (count_n == DEPTH_CNT);
            empty  <= (count_n == '0);
            head   <= head_n;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer with a drain-complete pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          send,
    input  logic [7:0]                    tx_byte,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          uart_tx,
    output logic                          done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t         state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [BIT_W-1:0]  bit_idx, bit_n;
    logic [7:0]        shift_q, shift_n;
    logic              tx_n;
    logic              done_n;
    logic              pop;
    logic              bit_end;
    logic [7:0]        fifo_head;
    logic              fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_n;
`endif

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (send),
        .din   (tx_byte),
        .pop   (pop),
        .head  (fifo_head),
        .full  (full),
        .empty (fifo_empty),
        .count (count)
    );

    assign bit_end = (baud_cnt == BAUD_LAST);

    // uart_tx is computed one step ahead so the pin itself comes straight from a flop.
    always_comb begin
        state_n = state;
        baud_n  = (state == IDLE || bit_end) ? '0 : baud_cnt + BAUD_W'(1);
        bit_n   = bit_idx;
        shift_n = shift_q;
        tx_n    = uart_tx;
        done_n  = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n = parity_q;
`endif
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = parity_q;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_idx + BIT_W'(1);
                        shift_n = shift_q >> 1;
                        tx_n    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
        if (pop) begin
            shift_n = fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_n = ^fifo_head;
`endif
        end
    end

    // NOTE: sequential state is updated with non-blocking '<=' only; the block above uses '='.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            uart_tx  <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift_q  <= shift_n;
            uart_tx  <= tx_n;
            done     <= done_n;
            busy     <= (state_n != IDLE);
            overflow <= overflow | (send & full);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_n;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honours UART_TX_PARITY_EN to expect 8E1 frames and run the parity scenario.
module tb_uart_tx_buffered;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       full, busy, overflow, uart_tx, done;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    uart_tx_buffered #(
        .CLK_FREQ   (400),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .send     (send),
        .tx_byte  (tx_byte),
        .full     (full),
        .count    (count),
        .busy     (busy),
        .overflow (overflow),
        .uart_tx  (uart_tx),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receive model: samples each bit mid-period, logs bytes, frame starts and parity bits.
    logic [7:0] rx_bytes[$];
    int         rx_start[$];
    int         rx_cnt[$];
    logic       rx_par[$];
    int         done_cyc[$];
    int         rx_err = 0;
    bit         rx_active = 1'b0;
    int         rx_t = 0;
    int         rx_s = 0;
    int         rx_i = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active && uart_tx === 1'b0) begin
            rx_active = 1'b1;
            rx_t = 0;
            rx_s = cyc;
            rx_cnt.push_back(int'(count));
        end
        if (!reset && rx_active) begin
            if (rx_t % CPB == CPB / 2) begin
                rx_i = rx_t / CPB;
                if (rx_i == 0) begin
                    if (uart_tx !== 1'b0) rx_err++;
                end else if (rx_i <= 8) begin
                    rx_sh[rx_i-1] = uart_tx;
                end else if (rx_i == FRAME_BITS - 1) begin
                    if (uart_tx !== 1'b1) rx_err++;
                    rx_bytes.push_back(rx_sh);
                    rx_start.push_back(rx_s);
                    rx_active = 1'b0;
                end else begin
                    rx_par.push_back(uart_tx);
                    if (uart_tx !== ^rx_sh) rx_err++;
                end
            end
            rx_t++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        send  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        rx_bytes.delete();
        rx_start.delete();
        rx_cnt.delete();
        rx_par.delete();
        done_cyc.delete();
        rx_err = 0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done_cyc.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic expected_line(input logic [7:0] b, input int k);
        int j;
        int bi;
        if (k < 2) return 1'b1;
        j  = k - 2;
        bi = j / CPB;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        if (FRAME_BITS == 11 && bi == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        logic [7:0] obs;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            obs = {uart_tx, done, busy, full, overflow, count};
            tests++;
            if (obs !== 8'b1000_0000) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", k, obs, 8'b1000_0000);
            end
        end
    endtask

    task automatic test_single();
        int   t0;
        int   k;
        logic exp_tx;
        logic exp_done;
        clear_logs();
        tick();
        t0 = cyc;
        tx_byte = 8'hA5;
        send = 1'b1;
        for (int n = 0; n <= FRAME + 4; n++) begin
            @(negedge clk);
            k = cyc - t0;
            exp_tx   = expected_line(8'hA5, k);
            exp_done = (k == FRAME + 2);
            tests++;
            if ({uart_tx, done} !== {exp_tx, exp_done}) begin
                fails++;
                $display("FAIL single_wave k=%0d got tx/done=%b%b want %b%b", k, uart_tx, done, exp_tx, exp_done);
            end
            tick();
            send = 1'b0;
        end
        tests++;
        if (rx_bytes.size() != 1 || rx_bytes[0] !== 8'hA5 || rx_err != 0) begin
            fails++;
            $display("FAIL single_rx got n=%0d err=%0d want one byte a5", rx_bytes.size(), rx_err);
        end
    endtask

    task automatic test_back_to_back();
        int          t0;
        bit          ok;
        logic [23:0] got;
        clear_logs();
        tick();
        t0 = cyc;
        tx_byte = 8'h01;
        send = 1'b1;
        tick();
        tx_byte = 8'h02;
        @(negedge clk);
        tests++;
        if (count !== 3'd1) begin
            fails++;
            $display("FAIL b2b_count1 got %0d want 1", count);
        end
        tick();
        tx_byte = 8'h03;
        @(negedge clk);
        tests++;
        if (count !== 3'd1) begin
            fails++;
            $display("FAIL b2b_count_pushpop got %0d want 1", count);
        end
        tick();
        send = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, count} !== {1'b1, 3'd2}) begin
            fails++;
            $display("FAIL b2b_count2 got busy=%b count=%0d want busy=1 count=2", busy, count);
        end
        wait_done(1, 3 * FRAME + 20, ok);
        repeat (5) tick();
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_done_timeout got no done want done");
        end
        got = (rx_bytes.size() == 3) ? {rx_bytes[0], rx_bytes[1], rx_bytes[2]} : 24'hxxxxxx;
        tests++;
        if (got !== 24'h010203 || rx_err != 0) begin
            fails++;
            $display("FAIL b2b_bytes got %h err=%0d want 010203", got, rx_err);
        end
        tests++;
        if (rx_start.size() != 3 || rx_start[1] - rx_start[0] != FRAME || rx_start[2] - rx_start[1] != FRAME) begin
            fails++;
            $display("FAIL b2b_gap got %0d starts want spacing %0d", rx_start.size(), FRAME);
        end
        tests++;
        if (rx_cnt.size() != 3 || rx_cnt[0] != 1 || rx_cnt[1] != 1 || rx_cnt[2] != 0) begin
            fails++;
            $display("FAIL b2b_count_decr got %0d entries want 1,1,0", rx_cnt.size());
        end
        tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != t0 + 2 + 3 * FRAME) begin
            fails++;
            $display("FAIL b2b_done_once got %0d pulses want 1 at +%0d", done_cyc.size(), 2 + 3 * FRAME);
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  vals [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [39:0] got;
        bit          ok;
        clear_logs();
        tick();
        for (int i = 0; i < 6; i++) begin
            tx_byte = vals[i];
            send = 1'b1;
            tick();
        end
        send = 1'b0;
        @(negedge clk);
        tests++;
        if ({full, count, overflow} !== {1'b1, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL ovf_full got full=%b count=%0d ovf=%b want 1/4/1", full, count, overflow);
        end
        wait_done(1, 5 * FRAME + 50, ok);
        repeat (3) tick();
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL ovf_done_timeout got no done want done");
        end
        got = (rx_bytes.size() == 5) ? {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3], rx_bytes[4]} : 40'hx;
        tests++;
        if (got !== 40'h1122334455 || rx_err != 0) begin
            fails++;
            $display("FAIL ovf_bytes got %h err=%0d want 1122334455", got, rx_err);
        end
        @(negedge clk);
        tests++;
        if ({overflow, full, count} !== {1'b1, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL ovf_sticky got ovf=%b full=%b count=%0d want 1/0/0", overflow, full, count);
        end
        tests++;
        if (done_cyc.size() != 1) begin
            fails++;
            $display("FAIL ovf_done_once got %0d want 1", done_cyc.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        clear_logs();
        tick();
        tx_byte = 8'hFF;
        send = 1'b1;
        tick();
        tx_byte = 8'h81;
        tick();
        send = 1'b0;
        // Now in the start cycle of the FF frame; data bit 3 spans +16..+19.
        repeat (17) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({uart_tx, done, busy, count, overflow} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL midrst_state got tx=%b done=%b busy=%b count=%0d ovf=%b want 1/0/0/0/0",
                     uart_tx, done, busy, count, overflow);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            tests++;
            if ({uart_tx, done} !== 2'b10) begin
                fails++;
                $display("FAIL midrst_quiet k=%0d got tx/done=%b%b want 10", k, uart_tx, done);
            end
        end
        tests++;
        if (done_cyc.size() != 0 || rx_bytes.size() != 0) begin
            fails++;
            $display("FAIL midrst_nothing got done=%0d bytes=%0d want 0/0", done_cyc.size(), rx_bytes.size());
        end
        tick();
        tx_byte = 8'h3C;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_done(1, FRAME + 20, ok);
        tests++;
        if (!ok || rx_bytes.size() != 1 || rx_bytes[0] !== 8'h3C || rx_err != 0) begin
            fails++;
            $display("FAIL midrst_after got ok=%b n=%0d err=%0d want one clean 3c", ok, rx_bytes.size(), rx_err);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int t0;
        bit ok;
        clear_logs();
        tick();
        t0 = cyc;
        tx_byte = 8'h07;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_done(1, FRAME + 20, ok);
        tests++;
        if (!ok || rx_par.size() != 1 || rx_par[0] !== 1'b1 || done_cyc[0] != t0 + 2 + 44) begin
            fails++;
            $display("FAIL parity_07 got n=%0d want parity 1 and done at +46", rx_par.size());
        end
        clear_logs();
        tick();
        tx_byte = 8'h03;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_done(1, FRAME + 20, ok);
        tests++;
        if (!ok || rx_par.size() != 1 || rx_par[0] !== 1'b0 || rx_err != 0) begin
            fails++;
            $display("FAIL parity_03 got n=%0d err=%0d want parity 0", rx_par.size(), rx_err);
        end
    endtask
`endif

    task automatic test_send_at_done();
        int t0;
        int d;
        bit ok;
        clear_logs();
        tick();
        t0 = cyc;
        d  = t0 + 2 + FRAME;
        tx_byte = 8'h5A;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (d - 1 - cyc) tick();
        tx_byte = 8'hC3;
        send = 1'b1;
        tick();
        send = 1'b0;
        @(negedge clk);
        tests++;
        if ({done, count, uart_tx} !== {1'b1, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL sad_done got done=%b count=%0d tx=%b want 1/1/1", done, count, uart_tx);
        end
        @(negedge clk);
        tests++;
        if ({done, count, uart_tx} !== {1'b0, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL sad_restart got done=%b count=%0d tx=%b want 0/0/0", done, count, uart_tx);
        end
        wait_done(2, FRAME + 20, ok);
        tests++;
        if (!ok || rx_bytes.size() != 2 || rx_bytes[0] !== 8'h5A || rx_bytes[1] !== 8'hC3) begin
            fails++;
            $display("FAIL sad_bytes got ok=%b n=%0d want 5a c3", ok, rx_bytes.size());
        end
        tests++;
        if (rx_start.size() != 2 || rx_start[1] - rx_start[0] != FRAME + 1 || done_cyc.size() != 2
            || done_cyc[1] != d + 1 + FRAME) begin
            fails++;
            $display("FAIL sad_timing got starts=%0d dones=%0d want spacing %0d", rx_start.size(),
                     done_cyc.size(), FRAME + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_send_at_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
